// File: rtl/bram_dual_seq.sv
// Load/drain sequencer for the dual-width scratch BRAM: narrow words stream in through
// port A, then the buffer is read back as wide words through port B into a 2-entry FIFO.
module bram_dual_seq #(
    parameter int A_WIDTH         = 32,
    parameter int COUNT           = 10,
    parameter int A_ADDRESS_WIDTH = 4,
    parameter int B_WIDTH         = 64,
    parameter int B_ADDRESS_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [A_WIDTH-1:0]         in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [B_WIDTH-1:0]         out_data,
    output logic                       out_last,
    output logic                       bram_ena,
    output logic                       bram_wea,
    output logic [A_ADDRESS_WIDTH-1:0] bram_addra,
    output logic [A_WIDTH-1:0]         bram_dina,
    output logic                       bram_enb,
    output logic                       bram_web,
    output logic [B_ADDRESS_WIDTH-1:0] bram_addrb,
    output logic [B_WIDTH-1:0]         bram_dinb,
    input  logic [B_WIDTH-1:0]         bram_doutb
);
    localparam int NUM_B = COUNT * A_WIDTH / B_WIDTH;
    localparam int RW    = B_ADDRESS_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t                     state_q, state_d;
    logic [A_ADDRESS_WIDTH-1:0] wcnt_q, wcnt_d;
    logic [RW-1:0]              rcnt_q, rcnt_d;
    logic [RW-1:0]              ocnt_q, ocnt_d;
    logic                       pending_q, pending_d;
    logic                       done_q, done_d;
    logic [B_WIDTH-1:0]         fifo0_q, fifo0_d, fifo1_q, fifo1_d;
    logic                       head_q, head_d;
    logic [1:0]                 fcnt_q, fcnt_d;

    logic       in_hs, pop, last_pop, issue, wr_slot;
    logic [2:0] occ;

    // Both streams: a word moves on a rising edge where valid and ready are both high;
    // the producer holds data stable while valid is high and ready is low.
    assign in_ready  = (state_q == LOAD);
    assign in_hs     = in_valid && in_ready;
    assign out_valid = (fcnt_q != 2'd0);
    assign out_data  = head_q ? fifo1_q : fifo0_q;
    assign pop       = out_valid && out_ready;
    assign last_pop  = pop && (ocnt_q == RW'(NUM_B - 1));
    assign out_last  = out_valid && (ocnt_q == RW'(NUM_B - 1));
    assign wr_slot   = head_q ^ fcnt_q[0];

    // A pop this cycle frees a slot, so a read may issue in its place for full throughput.
    assign occ   = {1'b0, fcnt_q} + {2'b00, pending_q} - {2'b00, pop};
    assign issue = (state_q == DRAIN) && (rcnt_q < RW'(NUM_B)) && (occ < 3'd2);

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign bram_ena   = in_hs;
    assign bram_wea   = in_hs;
    assign bram_addra = in_hs ? wcnt_q : '0;
    assign bram_dina  = in_hs ? in_data : '0;
    assign bram_enb   = issue;
    assign bram_addrb = issue ? rcnt_q[B_ADDRESS_WIDTH-1:0] : '0;
    assign bram_web   = 1'b0;
    assign bram_dinb  = '0;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;
        ocnt_d    = ocnt_q;
        pending_d = issue;
        done_d    = 1'b0;
        fifo0_d   = fifo0_q;
        fifo1_d   = fifo1_q;
        head_d    = head_q ^ pop;
        fcnt_d    = fcnt_q + {1'b0, pending_q} - {1'b0, pop};

        if (pending_q) begin
            if (wr_slot) fifo1_d = bram_doutb;
            else         fifo0_d = bram_doutb;
        end
        if (issue) rcnt_d = rcnt_q + 1'b1;
        if (pop)   ocnt_d = ocnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                if (in_hs) begin
                    if (wcnt_q == A_ADDRESS_WIDTH'(COUNT - 1)) begin
                        wcnt_d  = '0;
                        state_d = DRAIN;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    rcnt_d  = '0;
                    ocnt_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            ocnt_q    <= '0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            fifo0_q   <= '0;
            fifo1_q   <= '0;
            head_q    <= 1'b0;
            fcnt_q    <= 2'd0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            ocnt_q    <= ocnt_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            fifo0_q   <= fifo0_d;
            fifo1_q   <= fifo1_d;
            head_q    <= head_d;
            fcnt_q    <= fcnt_d;
        end
    end

endmodule
